// File: rtl/var_value_base_pkg.sv
// Shared SAT-bin definitions: 3-bit variable value encoding and the
// state encoding of the per-bin variable value store.
package var_value_base_pkg;

  localparam logic [1:0] VAL_FREE    = 2'b00;
  localparam logic [1:0] VAL_FALSE   = 2'b01;
  localparam logic [1:0] VAL_TRUE    = 2'b10;
  localparam logic [1:0] VAL_INVALID = 2'b11;

  // bits [2:1] carry the polarity, bit [0] marks an implied value
  typedef logic [2:0] var_val_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PROP     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_CONFLICT = 3'd3,
    ST_BKT      = 3'd4
  } vv_state_t;

  function automatic logic lane_set(input var_val_t v);
    return (v[2:1] != VAL_FREE);
  endfunction

endpackage

// File: rtl/var_value_base_var_entry.sv
// One variable's value/level register: direct write, implication capture
// with compare/conflict detection, and clear-by-level for backtracking.
module var_entry
  import var_value_base_pkg::*;
#(
  parameter int LVL_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  var_val_t             wr_value,
  input  logic [LVL_WIDTH-1:0] wr_level,
  input  logic                 prop_en,
  input  var_val_t             imp_value,
  input  logic                 cap_en,
  input  logic [LVL_WIDTH-1:0] cap_level,
  input  logic                 clr_en,
  input  logic [LVL_WIDTH-1:0] clr_level,
  output var_val_t             value,
  output logic                 is_new,
  output logic                 is_conflict
);

  var_val_t             value_r;
  logic [LVL_WIDTH-1:0] level_r;
  logic                 stored_free_s;

  assign value         = value_r;
  assign stored_free_s = (value_r[2:1] == VAL_FREE);

  // Classify the incoming implication lane against the stored value
  always_comb begin
    is_new      = 1'b0;
    is_conflict = 1'b0;
    if (prop_en && lane_set(imp_value)) begin
      if ((imp_value[2:1] == VAL_INVALID) ||
          (!stored_free_s && (value_r[2:1] != imp_value[2:1]))) begin
        is_conflict = 1'b1;
      end else if (stored_free_s) begin
        is_new = 1'b1;
      end else begin
        is_new = 1'b0;
      end
    end else begin
      is_conflict = 1'b0;
    end
  end

  // Value/level storage; captures are only committed on conflict-free rounds
  always_ff @(posedge clk) begin
    if (rst) begin
      value_r <= 3'b000;
      level_r <= {LVL_WIDTH{1'b0}};
    end else if (wr_en) begin
      value_r <= wr_value;
      level_r <= wr_level;
    end else if (cap_en && is_new) begin
      value_r <= {imp_value[2:1], 1'b1};
      level_r <= cap_level;
    end else if (clr_en && (level_r > clr_level)) begin
      value_r <= 3'b000;
      level_r <= {LVL_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/var_value_base.sv
// Per-bin variable store: drives values to the lit cells, sequences decisions,
// propagation to fixpoint, conflict reporting and level-based backtracking.
module var_value_base
  import var_value_base_pkg::*;
#(
  parameter int NUM_VARS   = 8,
  parameter int LVL_WIDTH  = 8,
  parameter int VIDX_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [VIDX_WIDTH-1:0]   load_idx_i,
  input  logic [2:0]              load_value_i,
  input  logic [LVL_WIDTH-1:0]    load_level_i,
  input  logic                    decide_valid_i,
  input  logic [LVL_WIDTH-1:0]    cur_level_i,
  input  logic                    bkt_valid_i,
  input  logic [LVL_WIDTH-1:0]    bkt_level_i,
  output logic [NUM_VARS*3-1:0]   var_value_o,
  input  logic [NUM_VARS*3-1:0]   var_value_i,
  output logic                    wr_o,
  output logic                    imp_drv_o,
  output logic                    prop_done_o,
  output logic                    conflict_o,
  output logic [VIDX_WIDTH-1:0]   conflict_idx_o
);

  vv_state_t             state_r, state_n_s;
  logic [VIDX_WIDTH-1:0] scan_idx_r;
  logic [LVL_WIDTH-1:0]  bkt_level_r;
  logic [LVL_WIDTH-1:0]  cur_level_r;

  var_val_t              value_s [NUM_VARS];
  logic [NUM_VARS-1:0]   new_vec_s, conf_vec_s, wr_sel_s, clr_sel_s;
  logic                  any_new_s, any_conf_s, prop_s, cap_s, last_scan_s, in_range_s;
  logic                  ld_s, dec_s, wr_n_s, done_n_s, conf_n_s;
  logic [VIDX_WIDTH-1:0] low_idx_s;
  var_val_t              wr_value_s;
  logic [LVL_WIDTH-1:0]  wr_level_s;

  assign in_range_s  = (int'(load_idx_i) < NUM_VARS);
  assign any_new_s   = |new_vec_s;
  assign any_conf_s  = |conf_vec_s;
  assign prop_s      = (state_r == ST_PROP);
  assign cap_s       = prop_s && !any_conf_s;
  assign last_scan_s = (scan_idx_r == VIDX_WIDTH'(NUM_VARS - 1));
  // a decision stores the polarity only, never the implied flag
  assign wr_value_s  = dec_s ? {load_value_i[2:1], 1'b0} : load_value_i;
  assign wr_level_s  = dec_s ? cur_level_i : load_level_i;

  for (genvar i = 0; i < NUM_VARS; i++) begin : g_var
    var_entry #(.LVL_WIDTH(LVL_WIDTH)) u_entry (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_sel_s[i]),
      .wr_value    (wr_value_s),
      .wr_level    (wr_level_s),
      .prop_en     (prop_s),
      .imp_value   (var_value_i[(NUM_VARS-1-i)*3 +: 3]),
      .cap_en      (cap_s),
      .cap_level   (cur_level_r),
      .clr_en      (clr_sel_s[i]),
      .clr_level   (bkt_level_r),
      .value       (value_s[i]),
      .is_new      (new_vec_s[i]),
      .is_conflict (conf_vec_s[i])
    );
    assign var_value_o[(NUM_VARS-1-i)*3 +: 3] = value_s[i];
  end

  // Per-entry write and backtrack-clear selects
  always_comb begin
    for (int i = 0; i < NUM_VARS; i++) begin
      wr_sel_s[i]  = (ld_s || dec_s) && (load_idx_i == VIDX_WIDTH'(i));
      clr_sel_s[i] = (state_r == ST_BKT) && (scan_idx_r == VIDX_WIDTH'(i));
    end
  end

  // Lowest conflicting index
  always_comb begin
    low_idx_s = {VIDX_WIDTH{1'b0}};
    for (int i = NUM_VARS - 1; i >= 0; i--) begin
      low_idx_s = conf_vec_s[i] ? VIDX_WIDTH'(i) : low_idx_s;
    end
  end

  // Next-state and next-pulse logic
  always_comb begin
    state_n_s = state_r;
    ld_s      = 1'b0;
    dec_s     = 1'b0;
    wr_n_s    = 1'b0;
    done_n_s  = 1'b0;
    conf_n_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bkt_valid_i) begin
          state_n_s = ST_BKT;
        end else if (decide_valid_i && in_range_s) begin
          dec_s     = 1'b1;
          wr_n_s    = 1'b1;
          state_n_s = ST_PROP;
        end else if (load_valid_i && in_range_s) begin
          ld_s   = 1'b1;
          wr_n_s = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_PROP: begin
        if (any_conf_s) begin
          conf_n_s  = 1'b1;
          state_n_s = ST_CONFLICT;
        end else if (any_new_s) begin
          wr_n_s    = 1'b1;
          state_n_s = ST_SETTLE;
        end else begin
          done_n_s  = 1'b1;
          state_n_s = ST_IDLE;
        end
      end
      ST_SETTLE:   state_n_s = ST_PROP;
      ST_CONFLICT: state_n_s = ST_IDLE;
      ST_BKT: begin
        if (last_scan_s) begin
          wr_n_s    = 1'b1;
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_BKT;
        end
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // State, latched operands and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      scan_idx_r     <= {VIDX_WIDTH{1'b0}};
      bkt_level_r    <= {LVL_WIDTH{1'b0}};
      cur_level_r    <= {LVL_WIDTH{1'b0}};
      load_ready_o   <= 1'b1;
      wr_o           <= 1'b0;
      imp_drv_o      <= 1'b0;
      prop_done_o    <= 1'b0;
      conflict_o     <= 1'b0;
      conflict_idx_o <= {VIDX_WIDTH{1'b0}};
    end else begin
      state_r      <= state_n_s;
      load_ready_o <= (state_n_s == ST_IDLE);
      imp_drv_o    <= (state_n_s == ST_PROP);
      wr_o         <= wr_n_s;
      prop_done_o  <= done_n_s;
      conflict_o   <= conf_n_s;
      if (conf_n_s) conflict_idx_o <= low_idx_s;
      scan_idx_r <= (state_r == ST_BKT) ? scan_idx_r + VIDX_WIDTH'(1'b1) : {VIDX_WIDTH{1'b0}};
      if ((state_r == ST_IDLE) && bkt_valid_i) bkt_level_r <= bkt_level_i;
      if (dec_s) cur_level_r <= cur_level_i;
    end
  end

endmodule

// File: doc/var_value_base.md
# var_value_base

Per-bin variable state store that owns the 3-bit value of every variable in a bin. It is the driving end of the literal-cell value bus: it drives current values to all lit cells and collects implications they return. It sequences decisions, unit propagation to a fixpoint, conflict detection and level-based backtracking. It sits beside the clause array of one bin and talks upward to the bin controller.

## Interface
- NUM_VARS, default 8: variables held in the bin (≥2).
- LVL_WIDTH, default 8: decision-level width.
- VIDX_WIDTH, default 3: index width; must satisfy 2**VIDX_WIDTH ≥ NUM_VARS.
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_valid_i  in  1  load one variable's value/level from the controller.
- load_ready_o  out  1  store is IDLE and accepts a load or a decision.
- load_idx_i  in  VIDX_WIDTH  variable index for load or decision.
- load_value_i  in  3  value for load.
- load_level_i  in  LVL_WIDTH  level for load.
- decide_valid_i  in  1  decision on load_idx_i with value load_value_i[2:1]; starts propagation.
- cur_level_i  in  LVL_WIDTH  current decision level.
- bkt_valid_i  in  1  start backtrack to bkt_level_i.
- bkt_level_i  in  LVL_WIDTH  target level.
- var_value_o  out  NUM_VARS*3  values to lit cells, var 0 in MSBs.
- var_value_i  in  NUM_VARS*3  OR-merged implications from lit cells, same packing.
- wr_o  out  1  lit-cell write strobe.
- imp_drv_o  out  1  enables lit-cell implication drive.
- prop_done_o  out  1  one-cycle pulse: fixpoint reached, no conflict.
- conflict_o  out  1  one-cycle pulse: conflict detected.
- conflict_idx_o  out  VIDX_WIDTH  lowest conflicting variable index, held until next conflict.

## Operation
- Value encoding: bits [2:1] = 00 free, 01 false, 10 true, 11 invalid; bit [0] = implied, set only for implied values. An incoming 11 counts as a conflict.
- Per variable the block stores value[2:0] and level[LVL_WIDTH-1:0].
- States: IDLE, PROP, SETTLE, CONFLICT, BKT.
- IDLE: load_ready_o=1.
  - load_valid_i writes the entry and pulses wr_o next cycle.
  - decide_valid_i writes {value,0} at level cur_level_i, pulses wr_o and goes to PROP.
  - Priority: bkt_valid_i > decide_valid_i > load_valid_i; lower-priority requests in the same cycle are dropped.
- PROP: imp_drv_o=1. Each var_value_i lane with [2:1]≠00 is compared with the stored value:
  - stored free: capture {value,1} at cur_level_i; this counts as new.
  - stored equal: ignore.
  - stored opposite, or incoming 11: conflict.
  - Any conflict goes to CONFLICT. Otherwise, any new capture goes to SETTLE. Otherwise pulse prop_done_o and go to IDLE.
- SETTLE: one cycle with wr_o=1 and imp_drv_o=0 so the lit cells re-evaluate, then back to PROP.
- CONFLICT: pulse conflict_o, latch conflict_idx_o (lowest index), go to IDLE. Captures from the conflicting cycle are discarded.
- BKT: scan index 0..NUM_VARS-1, one per cycle. Clear to 000/level 0 any entry with level > bkt_level_i. After the last index, pulse wr_o and go to IDLE.
- Load to an out-of-range index (≥NUM_VARS) is ignored.

## Timing
- Reset: all entries 000/level 0; state IDLE. Outputs after reset: load_ready_o=1, var_value_o=0, wr_o=0, imp_drv_o=0, prop_done_o=0, conflict_o=0, conflict_idx_o=0.
- var_value_o is registered and updates the cycle after the write.
- Load: accepted at edge N, visible at N+1, wr_o high at N+1.
- Decision to first PROP cycle: 1 cycle. Each implication round costs 2 cycles (PROP + SETTLE).
- Backtrack latency: NUM_VARS+1 cycles from bkt_valid_i to load_ready_o=1.
- Inputs other than var_value_i are ignored outside IDLE.
- rst asserted in any state returns to the reset condition at the next edge; a scan or propagation in flight is abandoned.

## Structure
- Shared package (extends the existing SAT package) holds:
  - VAL_FREE/VAL_FALSE/VAL_TRUE/VAL_INVALID constants;
  - the 3-bit value typedef;
  - the state enum.
- One sub-module, var_entry: a single variable's value/level register with capture, compare/conflict and clear-by-level logic; instantiated NUM_VARS times. The FSM and the lowest-index priority encoder live in the top module.

## Test plan
- Reset: var_value_o=0, load_ready_o=1, all pulses low.
- Load var 2 = 101, level 3 → var_value_o[17:15 - 6 +...] lane 2 = 101 next cycle, wr_o pulses once.
- Decide var 0 true at level 1; lit cells imply var 1=011 (false, implied) once, then nothing → var 1 stored 011 at level 1; prop_done_o pulses 4 cycles after the decision.
- Var 3 stored 100; incoming lane 3 = 011 during PROP → conflict_o pulse, conflict_idx_o=3, var 3 unchanged.
- Vars at levels 1, 2, 3, 2; backtrack to level 1 → only var 0 keeps its value; load_ready_o returns after 9 cycles (NUM_VARS=8).
- rst raised mid-BKT at scan index 4 → next cycle all entries 000, state IDLE.
